// File: rtl/cursor_input_ctrl.sv
// cursor_input_ctrl
// Front end for the tic-tac-toe core. It synchronizes and debounces six raw
// push-buttons and moves a 3x3 cursor that wraps at the edges. It also issues
// single-cycle place and clear strobes. Moves and places are ignored while the
// core shows its score screen.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   btn_up/down/left/right  raw cursor buttons (async, active-high)
//   btn_center      raw place button
//   btn_clear       raw board-clear button
//   mode_in         core mode: 0 = game, 1 = score screen
//   cursor_pos      selected cell, row*3+col (0..8)
//   set_pulse       one-cycle place strobe, aligned with the cell it refers to
//   clear_pulse     one-cycle board-clear strobe
module cursor_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  input  logic       btn_clear,
  input  logic       mode_in,
  output logic [3:0] cursor_pos,
  output logic       set_pulse,
  output logic       clear_pulse
);

  localparam int unsigned NB = 6;
  localparam int unsigned B_UP     = 0;
  localparam int unsigned B_DOWN   = 1;
  localparam int unsigned B_LEFT   = 2;
  localparam int unsigned B_RIGHT  = 3;
  localparam int unsigned B_CENTER = 4;
  localparam int unsigned B_CLEAR  = 5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0]    raw;
  logic [NB-1:0]    s1, s2;
  logic [NB-1:0]    stable, stable_d;
  logic [NB-1:0]    evt_q;
  logic [CNT_W-1:0] cnt [NB];

  logic [1:0] row, col, row_n, col_n;
  logic       set_n, clr_n;

  assign raw = {btn_clear, btn_center, btn_right, btn_left, btn_down, btn_up};

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [1:0] dec3(input logic [1:0] v);
    return (v == 2'd0) ? 2'd2 : v - 2'd1;
  endfunction

  // Synchronizer, debounce and press detection for all buttons.
  // The press is registered once more (evt_q) so the strobe/cursor update
  // lands DEBOUNCE_CYCLES+3 edges after the raw level is first sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      stable   <= '0;
      stable_d <= '0;
      evt_q    <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_d <= stable;
      evt_q    <= stable & ~stable_d;
      for (int unsigned i = 0; i < NB; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Clear overrides everything; a place blocks any move in the same cycle so
  // the strobe is paired with the cell that was selected when it was pressed.
  always_comb begin
    row_n = row;
    col_n = col;
    set_n = 1'b0;
    clr_n = 1'b0;
    if (evt_q[B_CLEAR]) begin
      clr_n = 1'b1;
      row_n = 2'd1;
      col_n = 2'd1;
    end else if (!mode_in) begin
      if (evt_q[B_CENTER]) begin
        set_n = 1'b1;
      end else if (evt_q[B_UP]) begin
        row_n = dec3(row);
      end else if (evt_q[B_DOWN]) begin
        row_n = inc3(row);
      end else if (evt_q[B_LEFT]) begin
        col_n = dec3(col);
      end else if (evt_q[B_RIGHT]) begin
        col_n = inc3(col);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row         <= 2'd1;
      col         <= 2'd1;
      cursor_pos  <= 4'd4;
      set_pulse   <= 1'b0;
      clear_pulse <= 1'b0;
    end else begin
      row         <= row_n;
      col         <= col_n;
      cursor_pos  <= {2'b00, row_n} * 4'd3 + {2'b00, col_n};
      set_pulse   <= set_n;
      clear_pulse <= clr_n;
    end
  end

endmodule

// File: tb/tb_cursor_input_ctrl.sv
module tb_cursor_input_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right, btn_center, btn_clear;
  logic       mode_in;
  logic [3:0] cursor_pos;
  logic       set_pulse, clear_pulse;

  int checks = 0;
  int errors = 0;

  cursor_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center), .btn_clear(btn_clear),
    .mode_in(mode_in), .cursor_pos(cursor_pos),
    .set_pulse(set_pulse), .clear_pulse(clear_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a level is accepted once the raw input has shown it on
  // D consecutive samples; an accepted rising level reaches the outputs four
  // edges after the sample that completed it.
  logic [5:0] m_last, m_acc;
  int         m_len [6];
  logic [5:0] m_pipe [$];
  int         m_row, m_col, m_pos;
  logic       m_set, m_clr;
  logic [5:0] m_r, m_p, m_a;
  bit         model_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_last = '0; m_acc = '0;
      for (int b = 0; b < 6; b++) m_len[b] = 0;
      m_pipe = {6'd0, 6'd0, 6'd0, 6'd0};
      m_row = 1; m_col = 1; m_pos = 4; m_set = 0; m_clr = 0;
    end else begin
      m_r = {btn_clear, btn_center, btn_right, btn_left, btn_down, btn_up};
      m_p = '0;
      for (int b = 0; b < 6; b++) begin
        m_len[b] = (m_r[b] == m_last[b]) ? m_len[b] + 1 : 1;
        m_last[b] = m_r[b];
        if (m_r[b] != m_acc[b] && m_len[b] >= D) begin
          m_acc[b] = m_r[b];
          m_p[b]   = m_r[b];
        end
      end
      m_pipe.push_back(m_p);
      m_a = m_pipe.pop_front();
      m_set = 0; m_clr = 0;
      if (m_a[5]) begin
        m_clr = 1; m_row = 1; m_col = 1;
      end else if (!mode_in) begin
        if (m_a[4])      m_set = 1;
        else if (m_a[0]) m_row = (m_row + 2) % 3;
        else if (m_a[1]) m_row = (m_row + 1) % 3;
        else if (m_a[2]) m_col = (m_col + 2) % 3;
        else if (m_a[3]) m_col = (m_col + 1) % 3;
      end
      m_pos = m_row * 3 + m_col;
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      chk("model_pos", int'(cursor_pos), m_pos);
      chk("model_set", int'(set_pulse), int'(m_set));
      chk("model_clr", int'(clear_pulse), int'(m_clr));
    end
  end

  // Pulse bookkeeping for the directed parts.
  int n_set, n_clr, set_at;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    if (set_pulse) begin n_set++; set_at = int'(cursor_pos); end
    if (clear_pulse) n_clr++;
  endtask

  task automatic drive(input logic [5:0] b);
    {btn_clear, btn_center, btn_right, btn_left, btn_down, btn_up} = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [5:0] btn;
    logic       mode;
    int         pos;
    int         sets;
    int         clears;
    int         setpos;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic [5:0] b, input logic m, input int p,
                     input int s, input int c, input int sp);
    vec_t v;
    v.btn = b; v.mode = m; v.pos = p; v.sets = s; v.clears = c; v.setpos = sp;
    tbl.push_back(v);
  endtask

  // bits: 0 up, 1 down, 2 left, 3 right, 4 center, 5 clear
  initial begin
    add(6'd8,  0, 5, 0, 0, 0);  // right
    add(6'd8,  0, 3, 0, 0, 0);  // right, col wraps 2->0
    add(6'd1,  0, 0, 0, 0, 0);  // up
    add(6'd1,  0, 6, 0, 0, 0);  // up, row wraps 0->2
    add(6'd32, 0, 4, 0, 1, 0);  // clear
    add(6'd18, 0, 4, 1, 0, 4);  // center+down: set at old cell, move blocked
    add(6'd2,  0, 7, 0, 0, 0);  // down
    add(6'd20, 1, 7, 0, 0, 0);  // score mode: center+left ignored
    add(6'd32, 1, 4, 0, 1, 0);  // score mode: clear still works
    add(6'd16, 0, 4, 1, 0, 4);  // center
    add(6'd4,  0, 3, 0, 0, 0);  // left
    add(6'd4,  0, 5, 0, 0, 0);  // left, col wraps 0->2
    add(6'd2,  0, 8, 0, 0, 0);  // down
    add(6'd2,  0, 2, 0, 0, 0);  // down, row wraps 2->0
    add(6'd8,  0, 0, 0, 0, 0);  // right
    add(6'd15, 0, 6, 0, 0, 0);  // all moves: up wins
    add(6'd56, 0, 4, 0, 1, 0);  // clear beats center and right
    add(6'd1,  1, 4, 0, 0, 0);  // score mode: up ignored
    add(6'd12, 0, 3, 0, 0, 0);  // left beats right
    add(6'd10, 0, 6, 0, 0, 0);  // down beats right

    rst = 1'b1; mode_in = 1'b0; drive(6'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pos", int'(cursor_pos), 4);
    chk("reset_set", int'(set_pulse), 0);
    chk("reset_clr", int'(clear_pulse), 0);
    rst = 1'b0;
    model_en = 1;

    // Hold right: exactly one move, visible after edge 7.
    drive(6'd8);
    n_set = 0; n_clr = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk($sformatf("t1_pos_e%0d", k), int'(cursor_pos), (k >= 7) ? 5 : 4);
    end
    chk("t1_sets", n_set, 0);
    drive(6'd0);
    repeat (10) cyc();

    // Bounce on up never settles long enough; a real hold then moves.
    do_reset();
    n_set = 0; n_clr = 0;
    begin
      logic [7:0] bounce;
      bounce = 8'b01110111;
      for (int k = 0; k < 8; k++) begin
        drive({5'd0, bounce[k]});
        cyc();
      end
    end
    drive(6'd0);
    repeat (12) cyc();
    chk("t3_bounce_pos", int'(cursor_pos), 4);
    drive(6'd1);
    repeat (10) cyc();
    drive(6'd0);
    repeat (10) cyc();
    chk("t3_hold_pos", int'(cursor_pos), 1);

    // Table-driven presses, each held 10 cycles then released 10.
    do_reset();
    foreach (tbl[i]) begin
      n_set = 0; n_clr = 0; set_at = -1;
      mode_in = tbl[i].mode;
      drive(tbl[i].btn);
      repeat (10) cyc();
      drive(6'd0);
      repeat (10) cyc();
      chk($sformatf("vec%0d_pos", i), int'(cursor_pos), tbl[i].pos);
      chk($sformatf("vec%0d_sets", i), n_set, tbl[i].sets);
      chk($sformatf("vec%0d_clears", i), n_clr, tbl[i].clears);
      if (tbl[i].sets > 0)
        chk($sformatf("vec%0d_setpos", i), set_at, tbl[i].setpos);
    end
    mode_in = 1'b0;

    // Center held through a mid-debounce reset: one set, 7 edges after reset.
    n_set = 0; n_clr = 0;
    drive(6'd16);
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk($sformatf("t6_set_e%0d", k), int'(set_pulse), (k == 7) ? 1 : 0);
    end
    drive(6'd0);
    repeat (10) cyc();
    chk("t6_sets", n_set, 1);

    // Random buttons, mode and occasional reset against the model.
    begin
      logic [5:0] b;
      b = '0;
      for (int n = 0; n < 3000; n++) begin
        for (int k = 0; k < 6; k++)
          if ($urandom_range(0, 5) == 0) b[k] = ~b[k];
        drive(b);
        if ($urandom_range(0, 39) == 0) mode_in = ~mode_in;
        rst = ($urandom_range(0, 399) == 0);
        cyc();
      end
      rst = 1'b0;
      drive(6'd0);
      repeat (10) cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
